branch_resolve_unit: RTL and testbench

- Multi-lane branch resolution stage for the LoongArch execute pipeline.
- Resolves up to LANES branch/jump ops per cycle against their predictions.
- Selects the oldest mispredicting lane, issues a registered flush/redirect and squashes younger lanes.
- Queues predictor training records in an update FIFO with a valid/ready handshake to the BTB/PHT.

---
 rtl/branch_resolve_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: multi-lane branch resolution for the execute stage.
//   Resolves up to LANES branch/jump ops per cycle, picks the oldest
//   mispredicting lane, emits a registered one-cycle flush/redirect and
//   squashes younger lanes. Predictor training records go into a small
//   multi-push / single-pop FIFO drained with a valid/ready handshake.
// Ports:
//   clk, rst_n (sync, active low), flush_i (external kill)
//   valid_i/pc_i/inst_i/aluop_i/reg1_i/reg2_i/pre_taken_i/pre_addr_i : per-lane
//     inputs, lane k at [W*k +: W]; lane 0 is oldest
//   stall_o : queue cannot absorb LANES pushes, upstream holds
//   wb_valid_o/wb_data_o : registered lane result (link value pc+FALLTHRU)
//   flush_o/redirect_pc_o : registered redirect pulse and target
//   upd_* : update-queue head and handshake toward BTB/PHT

// Per-lane resolve: target, taken, actual next pc and mispredict flag.
module branch_resolve_lane #(
  parameter int unsigned FALLTHRU = 4,
  parameter logic [7:0]  ALU_BEQ  = 8'h50,
  parameter logic [7:0]  ALU_BNE  = 8'h51,
  parameter logic [7:0]  ALU_BLT  = 8'h52,
  parameter logic [7:0]  ALU_BGE  = 8'h53,
  parameter logic [7:0]  ALU_BLTU = 8'h54,
  parameter logic [7:0]  ALU_BGEU = 8'h55,
  parameter logic [7:0]  ALU_B    = 8'h56,
  parameter logic [7:0]  ALU_BL   = 8'h57,
  parameter logic [7:0]  ALU_JIRL = 8'h58
) (
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [7:0]  aluop,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic        pre_taken,
  input  logic [31:0] pre_addr,
  output logic        is_br,
  output logic        cond,
  output logic        taken,
  output logic [31:0] actual,
  output logic        mispred
);
  logic [31:0] off16, off26, target;

  assign off16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign off26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  always_comb begin
    is_br  = 1'b1;
    cond   = 1'b1;
    taken  = 1'b0;
    target = pc + off16;
    case (aluop)
      ALU_BEQ:  taken = (reg1 == reg2);
      ALU_BNE:  taken = (reg1 != reg2);
      ALU_BLT:  taken = ($signed(reg1) <  $signed(reg2));
      ALU_BGE:  taken = ($signed(reg1) >= $signed(reg2));
      ALU_BLTU: taken = (reg1 <  reg2);
      ALU_BGEU: taken = (reg1 >= reg2);
      ALU_B, ALU_BL: begin
        cond   = 1'b0;
        taken  = 1'b1;
        target = pc + off26;
      end
      ALU_JIRL: begin
        cond   = 1'b0;
        taken  = 1'b1;
        target = reg1 + off16;
      end
      default: begin
        is_br = 1'b0;
        cond  = 1'b0;
      end
    endcase
  end

  assign actual  = taken ? target : pc + 32'(FALLTHRU);
  // a taken-taken pair still mispredicts when the predicted target is stale
  assign mispred = is_br & ((taken != pre_taken) |
                            (taken & pre_taken & (pre_addr != target)));
endmodule

module branch_resolve_unit #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned UPQ_DEPTH = 4,
  parameter int unsigned FALLTHRU  = 4,
  parameter logic [7:0]  ALU_BEQ   = 8'h50,
  parameter logic [7:0]  ALU_BNE   = 8'h51,
  parameter logic [7:0]  ALU_BLT   = 8'h52,
  parameter logic [7:0]  ALU_BGE   = 8'h53,
  parameter logic [7:0]  ALU_BLTU  = 8'h54,
  parameter logic [7:0]  ALU_BGEU  = 8'h55,
  parameter logic [7:0]  ALU_B     = 8'h56,
  parameter logic [7:0]  ALU_BL    = 8'h57,
  parameter logic [7:0]  ALU_JIRL  = 8'h58
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [LANES-1:0]      valid_i,
  input  logic [32*LANES-1:0]   pc_i,
  input  logic [32*LANES-1:0]   inst_i,
  input  logic [8*LANES-1:0]    aluop_i,
  input  logic [32*LANES-1:0]   reg1_i,
  input  logic [32*LANES-1:0]   reg2_i,
  input  logic [LANES-1:0]      pre_taken_i,
  input  logic [32*LANES-1:0]   pre_addr_i,
  output logic                  stall_o,
  output logic [LANES-1:0]      wb_valid_o,
  output logic [32*LANES-1:0]   wb_data_o,
  output logic                  flush_o,
  output logic [31:0]           redirect_pc_o,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output logic [31:0]           upd_pc_o,
  output logic [31:0]           upd_target_o,
  output logic                  upd_taken_o,
  output logic                  upd_cond_o,
  output logic                  upd_mispred_o
);
  localparam int unsigned PW = (UPQ_DEPTH > 1) ? $clog2(UPQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(UPQ_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        cond;
    logic        mispred;
  } upd_t;

  logic [LANES-1:0][31:0] pc_v, inst_v, reg1_v, reg2_v, pa_v, actual_v;
  logic [LANES-1:0][7:0]  op_v;
  logic [LANES-1:0]       is_br, cond, taken, mispred;

  assign pc_v   = pc_i;
  assign inst_v = inst_i;
  assign reg1_v = reg1_i;
  assign reg2_v = reg2_i;
  assign pa_v   = pre_addr_i;
  assign op_v   = aluop_i;

  // opcode bits are decoded upstream into aluop
  logic unused_inst_hi;
  always_comb begin
    unused_inst_hi = 1'b0;
    for (int k = 0; k < LANES; k++) unused_inst_hi = unused_inst_hi ^ (^inst_v[k][31:26]);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    branch_resolve_lane #(
      .FALLTHRU(FALLTHRU), .ALU_BEQ(ALU_BEQ), .ALU_BNE(ALU_BNE), .ALU_BLT(ALU_BLT),
      .ALU_BGE(ALU_BGE), .ALU_BLTU(ALU_BLTU), .ALU_BGEU(ALU_BGEU), .ALU_B(ALU_B),
      .ALU_BL(ALU_BL), .ALU_JIRL(ALU_JIRL)
    ) u_lane (
      .pc(pc_v[k]), .inst(inst_v[k][25:0]), .aluop(op_v[k]),
      .reg1(reg1_v[k]), .reg2(reg2_v[k]),
      .pre_taken(pre_taken_i[k]), .pre_addr(pa_v[k]),
      .is_br(is_br[k]), .cond(cond[k]), .taken(taken[k]),
      .actual(actual_v[k]), .mispred(mispred[k])
    );
  end

  // state
  logic [LANES-1:0]       wb_valid_q;
  logic [LANES-1:0][31:0] wb_data_q;
  logic                   flush_q;      // also the one-cycle wrong-path shadow
  logic [31:0]            redirect_q;
  upd_t                   q_mem [UPQ_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;

  // accept / squash / push compaction
  logic [LANES-1:0]         acc, push;
  logic [LANES-1:0][CW-1:0] slot;
  logic [CW-1:0]            n_push;
  logic                     gate, older_bad, redir_en, pop;
  logic [31:0]              redir_pc;

  assign stall_o     = (CW'(UPQ_DEPTH) - count) < CW'(LANES);
  assign gate        = ~stall_o & ~flush_q & ~flush_i;
  assign upd_valid_o = (count != '0);
  assign pop         = upd_valid_o & upd_ready_i;

  always_comb begin
    older_bad = 1'b0;
    n_push    = '0;
    redir_en  = 1'b0;
    redir_pc  = '0;
    acc       = '0;
    push      = '0;
    slot      = '0;
    for (int k = 0; k < LANES; k++) begin
      acc[k]  = valid_i[k] & gate & ~older_bad;
      push[k] = acc[k] & is_br[k];
      slot[k] = n_push;                 // packed position among this cycle's pushes
      n_push  = n_push + CW'(push[k]);
      // at most one accepted lane can mispredict: everything younger is killed
      if (acc[k] & mispred[k]) begin
        redir_en = 1'b1;
        redir_pc = actual_v[k];
      end
      older_bad = older_bad | (valid_i[k] & mispred[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      wb_valid_q <= acc;
      for (int k = 0; k < LANES; k++)
        if (acc[k]) wb_data_q[k] <= pc_v[k] + 32'(FALLTHRU);
      flush_q <= redir_en;
      if (redir_en) redirect_q <= redir_pc;
      for (int k = 0; k < LANES; k++)
        if (push[k])
          q_mem[wr_ptr + slot[k][PW-1:0]] <= '{pc_v[k], actual_v[k], taken[k], cond[k], mispred[k]};
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + n_push - CW'(pop);
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_data_q;
  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;
  assign upd_pc_o      = q_mem[rd_ptr].pc;
  assign upd_target_o  = q_mem[rd_ptr].target;
  assign upd_taken_o   = q_mem[rd_ptr].taken;
  assign upd_cond_o    = q_mem[rd_ptr].cond;
  assign upd_mispred_o = q_mem[rd_ptr].mispred;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: an in-bench reference model
// (queue-based) compared every cycle, plus literal expectations per scenario.
module tb_branch_resolve_unit;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam logic [7:0] OP_BEQ = 8'h50, OP_BNE = 8'h51, OP_BLT = 8'h52, OP_BGE = 8'h53,
                         OP_BLTU = 8'h54, OP_BGEU = 8'h55, OP_B = 8'h56, OP_BL = 8'h57,
                         OP_JIRL = 8'h58, OP_ADD = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic upd_ready_i = 1'b0;
  logic [LANES-1:0] valid_i, pre_taken_i;
  logic [LANES-1:0][31:0] pc_i, inst_i, reg1_i, reg2_i, pre_addr_i;
  logic [LANES-1:0][7:0] aluop_i;
  logic stall_o, flush_o, upd_valid_o, upd_taken_o, upd_cond_o, upd_mispred_o;
  logic [LANES-1:0] wb_valid_o;
  logic [LANES-1:0][31:0] wb_data_o;
  logic [31:0] redirect_pc_o, upd_pc_o, upd_target_o;

  branch_resolve_unit #(.LANES(LANES), .UPQ_DEPTH(DEPTH), .FALLTHRU(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .pc_i(pc_i),
    .inst_i(inst_i), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .pre_taken_i(pre_taken_i), .pre_addr_i(pre_addr_i), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .flush_o(flush_o),
    .redirect_pc_o(redirect_pc_o), .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o),
    .upd_cond_o(upd_cond_o), .upd_mispred_o(upd_mispred_o));

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic tk, cd, mp;
  } rec_t;

  rec_t        mq[$];
  rec_t        nw[$];
  logic [LANES-1:0] m_wbv;
  logic [31:0] m_wbd[LANES];
  logic        m_flush;
  logic [31:0] m_redir;
  bit          m_ok = 0;
  bit          m_br, m_cd, m_tk, m_mp, m_stop;
  logic [31:0] m_act;

  function automatic void resolve(input logic [31:0] pc, input logic [31:0] inst,
      input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
      input logic pt, input logic [31:0] pa,
      output bit br, output bit cd, output bit tk, output logic [31:0] act, output bit mp);
    logic signed [15:0] i16;
    logic signed [25:0] i26;
    int o16, o26;
    logic [31:0] tgt;
    i16 = inst[25:10];
    i26 = {inst[9:0], inst[25:10]};
    o16 = int'(i16) * 4;
    o26 = int'(i26) * 4;
    br = 1; cd = 1; tk = 0; tgt = pc + 32'(o16);
    case (op)
      OP_BEQ:  tk = (r1 == r2);
      OP_BNE:  tk = (r1 != r2);
      OP_BLT:  tk = ($signed(r1) < $signed(r2));
      OP_BGE:  tk = !($signed(r1) < $signed(r2));
      OP_BLTU: tk = (r1 < r2);
      OP_BGEU: tk = !(r1 < r2);
      OP_B, OP_BL: begin cd = 0; tk = 1; tgt = pc + 32'(o26); end
      OP_JIRL: begin cd = 0; tk = 1; tgt = r1 + 32'(o16); end
      default: begin br = 0; cd = 0; end
    endcase
    act = tk ? tgt : pc + 32'd4;
    mp = br && ((tk != pt) || (tk && pt && pa != tgt));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_wbv = '0;
      for (int k = 0; k < LANES; k++) m_wbd[k] = '0;
      m_flush = 0;
      m_redir = '0;
      m_ok = 1;
    end else begin
      nw.delete();
      m_stop = flush_i || ((DEPTH - mq.size()) < LANES) || m_flush;
      m_flush = 0;
      m_wbv = '0;
      for (int k = 0; k < LANES; k++) begin
        if (!m_stop && valid_i[k]) begin
          resolve(pc_i[k], inst_i[k], aluop_i[k], reg1_i[k], reg2_i[k], pre_taken_i[k],
                  pre_addr_i[k], m_br, m_cd, m_tk, m_act, m_mp);
          m_wbv[k] = 1;
          m_wbd[k] = pc_i[k] + 32'd4;
          if (m_br) nw.push_back('{pc_i[k], m_act, m_tk, m_cd, m_mp});
          if (m_mp) begin m_flush = 1; m_redir = m_act; m_stop = 1; end
        end
      end
      if (mq.size() != 0 && upd_ready_i) void'(mq.pop_front());
      foreach (nw[i]) mq.push_back(nw[i]);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_wb_valid", wb_valid_o, m_wbv);
      for (int k = 0; k < LANES; k++)
        if (m_wbv[k]) chk("m_wb_data", wb_data_o[k], m_wbd[k]);
      chk("m_flush", flush_o, m_flush);
      chk("m_redirect", redirect_pc_o, m_redir);
      chk("m_stall", stall_o, (DEPTH - mq.size()) < LANES);
      chk("m_upd_valid", upd_valid_o, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_upd_pc", upd_pc_o, mq[0].pc);
        chk("m_upd_target", upd_target_o, mq[0].tgt);
        chk("m_upd_taken", upd_taken_o, mq[0].tk);
        chk("m_upd_cond", upd_cond_o, mq[0].cd);
        chk("m_upd_mispred", upd_mispred_o, mq[0].mp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk16(input logic [31:0] off);
    logic [31:0] v;
    v = off >> 2;
    return {6'b0, v[15:0], 10'b0};
  endfunction

  function automatic logic [31:0] mk26(input logic [31:0] off);
    logic [31:0] v;
    v = off >> 2;
    return {6'b0, v[15:0], v[25:16]};
  endfunction

  task automatic idle();
    valid_i = '0; pre_taken_i = '0; flush_i = 0;
    for (int k = 0; k < LANES; k++) begin
      pc_i[k] = '0; inst_i[k] = '0; reg1_i[k] = '0; reg2_i[k] = '0;
      pre_addr_i[k] = '0; aluop_i[k] = '0;
    end
  endtask

  task automatic set_lane(input int k, input logic [7:0] op, input logic [31:0] pc,
      input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
      input logic pt, input logic [31:0] pa);
    valid_i[k] = 1; aluop_i[k] = op; pc_i[k] = pc; inst_i[k] = inst;
    reg1_i[k] = r1; reg2_i[k] = r2; pre_taken_i[k] = pt; pre_addr_i[k] = pa;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_redirect", redirect_pc_o, 0);
    chk("rst_upd_valid", upd_valid_o, 0);
    chk("rst_stall", stall_o, 0);

    // BEQ taken, predicted correctly
    set_lane(0, OP_BEQ, 32'h1c000000, mk16(32'h10), 5, 5, 1, 32'h1c000010);
    step(); idle();
    chk("beq_wb_valid", wb_valid_o, 2'b01);
    chk("beq_wb_data", wb_data_o[0], 32'h1c000004);
    chk("beq_flush", flush_o, 0);
    chk("beq_head_pc", upd_pc_o, 32'h1c000000);
    chk("beq_head_tgt", upd_target_o, 32'h1c000010);
    chk("beq_head_flags", {upd_taken_o, upd_cond_o, upd_mispred_o}, 3'b110);
    upd_ready_i = 1;
    step();
    chk("beq_drained", upd_valid_o, 0);
    upd_ready_i = 0;

    // BNE mispredicted on lane0 squashes BL on lane1
    set_lane(0, OP_BNE, 32'h1c000100, mk16(32'h40), 3, 3, 1, 32'h1c000140);
    set_lane(1, OP_BL, 32'h1c000104, mk26(32'h1000), 0, 0, 1, 32'h1c001104);
    step();
    chk("bne_flush", flush_o, 1);
    chk("bne_redirect", redirect_pc_o, 32'h1c000104);
    chk("bne_wb_valid", wb_valid_o, 2'b01);
    chk("bne_head_pc", upd_pc_o, 32'h1c000100);
    chk("bne_head_flags", {upd_taken_o, upd_mispred_o}, 2'b01);
    step();  // same bundle held: shadow cycle
    chk("shadow_wb_valid", wb_valid_o, 2'b00);
    chk("shadow_flush", flush_o, 0);
    idle();
    upd_ready_i = 1;
    step();
    chk("bne_one_push", upd_valid_o, 0);

    // BLT signed taken (correct), BLTU unsigned not taken (mispredict)
    set_lane(0, OP_BLT, 32'h1c000200, mk16(32'h20), 32'hFFFFFFFF, 1, 1, 32'h1c000220);
    step(); idle();
    chk("blt_flush", flush_o, 0);
    chk("blt_taken", upd_taken_o, 1);
    step();
    set_lane(0, OP_BLTU, 32'h1c000210, mk16(32'h20), 32'hFFFFFFFF, 1, 1, 32'h1c000230);
    step(); idle();
    chk("bltu_flush", flush_o, 1);
    chk("bltu_redirect", redirect_pc_o, 32'h1c000214);
    chk("bltu_taken", upd_taken_o, 0);
    step();

    // JIRL with stale predicted target
    set_lane(0, OP_JIRL, 32'h1c000300, mk16(32'h8), 32'h1c001000, 0, 1, 32'h1c001004);
    step(); idle();
    chk("jirl_flush", flush_o, 1);
    chk("jirl_redirect", redirect_pc_o, 32'h1c001008);
    chk("jirl_link", wb_data_o[0], 32'h1c000304);
    chk("jirl_cond", upd_cond_o, 0);
    step();

    // non-branch lane0 writes back only; lane1 B mispredicted not-taken
    set_lane(0, OP_ADD, 32'h1c000500, 0, 1, 2, 0, 0);
    set_lane(1, OP_B, 32'h1c000504, mk26(32'h100), 0, 0, 0, 0);
    step(); idle();
    chk("alu_b_wb_valid", wb_valid_o, 2'b11);
    chk("alu_b_redirect", redirect_pc_o, 32'h1c000604);
    chk("alu_b_head_pc", upd_pc_o, 32'h1c000504);
    step();
    chk("alu_b_one_push", upd_valid_o, 0);

    // fill the queue with backpressure
    upd_ready_i = 0;
    set_lane(0, OP_BEQ, 32'h1c000400, mk16(32'h40), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1c000404, mk16(32'h40), 7, 7, 1, 32'h1c000444);
    step();
    chk("fill1_stall", stall_o, 0);
    set_lane(0, OP_BEQ, 32'h1c000410, mk16(32'h40), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1c000414, mk16(32'h40), 7, 7, 1, 32'h1c000454);
    step();
    chk("fill2_stall", stall_o, 1);
    chk("fill2_wb_valid", wb_valid_o, 2'b11);
    set_lane(0, OP_BEQ, 32'h1c000420, mk16(32'h40), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1c000424, mk16(32'h40), 7, 7, 1, 32'h1c000464);
    step();
    chk("stalled_wb_valid", wb_valid_o, 2'b00);
    step();
    chk("stalled_wb_valid2", wb_valid_o, 2'b00);
    idle();
    chk("drain_head0", upd_pc_o, 32'h1c000400);
    upd_ready_i = 1;
    step();
    chk("drain_head1", upd_pc_o, 32'h1c000404);
    chk("drain_stall3", stall_o, 1);
    step();
    chk("drain_head2", upd_pc_o, 32'h1c000410);
    chk("drain_stall2", stall_o, 0);
    step();
    chk("drain_head3", upd_pc_o, 32'h1c000414);
    step();
    chk("drain_empty", upd_valid_o, 0);

    // external flush kills a mispredicting lane; queue survives until reset
    upd_ready_i = 0;
    set_lane(0, OP_BEQ, 32'h1c000700, mk16(32'h10), 4, 4, 1, 32'h1c000710);
    step(); idle();
    set_lane(0, OP_BNE, 32'h1c000800, mk16(32'h40), 9, 9, 1, 32'h1c000840);
    flush_i = 1;
    step(); idle();
    chk("xflush_flush", flush_o, 0);
    chk("xflush_wb_valid", wb_valid_o, 2'b00);
    chk("xflush_head", upd_pc_o, 32'h1c000700);
    chk("xflush_kept", upd_valid_o, 1);
    rst_n = 0;
    step();
    chk("rst2_upd_valid", upd_valid_o, 0);
    chk("rst2_stall", stall_o, 0);
    rst_n = 1;
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
